// File: rtl/mmio_fabric.sv
// Single-master MMIO interconnect: decodes the top address bits to one of
// N_SLAVES valid/ready ports, holds the registered request until the slave
// answers, and turns unmapped or timed-out accesses into bus errors with an
// error-address log, a saturating error counter and a one-cycle error pulse.
module mmio_fabric #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          SEL_BITS = 3,
    parameter int          N_SLAVES = 8,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_valid,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_ready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_err,
    output logic [N_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [DATA_W/8-1:0]        s_wstrb,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [7:0]                 err_count,
    output logic                       err_irq
);

    localparam int STRB_W = DATA_W / 8;
    // Wide enough to hold TIMEOUT; a disabled timeout still needs one bit.
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [7:0]          err_count_q, err_count_d;

    logic [SEL_BITS-1:0] m_sel;
    logic                mapped;
    logic                ready_hit;
    logic                timeout_hit;
    logic [DATA_W-1:0]   sel_rdata;

    // Slave-side decode: one-hot request, selected ready and selected read data.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block can leave it unassigned (latch).
        s_valid   = '0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            s_valid[k] = (state_q == WAIT) && (32'(sel_q) == 32'(k));
            if (s_valid[k]) begin
                sel_rdata = s_rdata[k*DATA_W +: DATA_W];
            end
        end
        // Only the slave currently being requested can complete the access.
        ready_hit   = |(s_ready & s_valid);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
        m_sel       = m_addr[ADDR_W-1 -: SEL_BITS];
        mapped      = 32'(m_sel) < 32'(N_SLAVES);
    end

    // Next-state and datapath update for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_valid) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    sel_d   = m_sel;
                    if (mapped) begin
                        err_d   = 1'b0;
                        state_d = WAIT;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = DATA_W'(ERR_DATA);
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (ready_hit) begin
                    rdata_d = sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = DATA_W'(ERR_DATA);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                // m_valid is deliberately ignored here so one request is
                // never accepted twice.
                if (err_q) begin
                    err_addr_d = addr_q;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value regardless of ordering.
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_ready   = (state_q == RESP);
    assign m_err     = m_ready & err_q;
    assign err_irq   = m_ready & err_q;
    assign m_rdata   = rdata_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule
